sound_event_sequencer: RTL and testbench
========================================

# sound_event_sequencer

Upstream stage of the snake-game sound path. Converts raw game-event levels (good collision, bad collision, direction buttons) into timed tone requests with a fixed duration, priority and a one-deep pending latch per event class. Drives `freq_o`/`playSound_o` into the oscillator, replacing direct level-driven selection so every event produces a complete, audible note or jingle.

## Interface
- `TONE_TICKS`, default 20: clk cycles per note (0.2 s at 100 Hz); must be ≥2.
- `GAP_TICKS`, default 2: silent cycles between consecutive notes or sounds; must be ≥1.
- `clk` input 1: system clock (hz100).
- `nRst` input 1: reset, asynchronous, active-low.
- `enable` input 1: high when sound mode is ON.
- `goodColl_i` input 1: good-collision level, already synchronous to clk.
- `badColl_i` input 1: bad-collision level.
- `direction_i` input 4: direction button levels.
- `freq_o` output 8: oscillator period code.
- `playSound_o` output 1: tone active.
- `busy_o` output 1: FSM not in IDLE.
- `dropped_o` output 1: one-cycle pulse when an event is lost.

## Operation
- Rising-edge detection on `goodColl_i`, `badColl_i` and `|direction_i`, using a registered previous value per input. An edge is `in & ~prev`.
- Pending flags: `pend_bad`, `pend_good`, `pend_dir`. Each is set on its edge and cleared when that sound starts.
- If an edge arrives while its flag is already set, assert `dropped_o` for 1 cycle. The flag stays set.
- Priority when starting a sound: bad > good > dir.
- Sounds:
  - bad: one note, D# (126), lasting 2×TONE_TICKS.
  - good: C (149) for TONE_TICKS, then GAP, then A (89) for TONE_TICKS.
  - dir: one note, C (149), for TONE_TICKS.
- FSM states and transitions:
  - IDLE: go to NOTE1 when any flag is set.
  - NOTE1: on timer expiry, go to GAP.
  - GAP: if the jingle is unfinished, go to NOTE2. Otherwise go to IDLE, or directly back to NOTE1 if another flag is set.
  - NOTE2: on timer expiry, go to GAP (final).
- Preemption: a bad edge during a good or dir sound aborts it. The next cycle enters NOTE1 with the bad sound, and the aborted sound is discarded. A bad edge during a bad sound only sets `pend_bad`.
- Outputs by state:
  - `playSound_o` = 1 only in NOTE1 and NOTE2.
  - `freq_o` holds the current note's code and keeps its last value in GAP and IDLE.
- `enable` low: on the next edge the FSM goes to IDLE, all pending flags clear, `playSound_o` = 0, and edges are ignored. Edge-detect registers keep tracking.
- Timer: down-counter of width `$clog2(2*TONE_TICKS)`, loaded on state entry. A state lasts exactly its tick count; there is no wrap-around.

## Timing
- Reset values: state IDLE, flags 0, prev registers 0, timer 0, `freq_o` = 0, `playSound_o` = 0, `busy_o` = 0, `dropped_o` = 0.
- Latency: input first sampled high at edge k → flag set at k → NOTE1 entered with `playSound_o` = 1 at edge k+1.
- An edge in the same cycle the FSM starts a sound of that class re-sets the flag. It is not dropped.
- Simultaneous edges of different classes set all the flags. They are played in priority order, each separated by GAP_TICKS.
- A level held high produces no further events.
- Reset asserted mid-sound: outputs go to reset values immediately (asynchronous).

## Structure
- The shared sound package holds:
  - `MODE_TYPES`
  - note constants `NOTE_A` = 89, `NOTE_DS` = 126, `NOTE_C` = 149
  - the `SEQ_STATE` enum {IDLE, NOTE1, GAP, NOTE2}
  - the `SND_KIND` enum {NONE, BAD, GOOD, DIR}
- One sub-module, `rise_latch`: edge detect plus pending flag plus drop pulse. It is instantiated three times.
- The timer and FSM live in the top of the block.

## Test plan
- Single `goodColl_i` pulse at edge 10:
  - `playSound_o` is high on edges 11–30 with freq 149.
  - It is low on edges 31–32.
  - It is high on edges 33–52 with freq 89.
  - `busy_o` falls at edge 55.
- `badColl_i` and `direction_i[0]` rise in the same cycle (edge 10): D# plays for 40 cycles (edges 11–50), then after a 2-cycle gap C plays for 20 cycles.
- Dir sound in progress, then a `badColl_i` edge at edge 15: `freq_o` = 126 from edge 16 for 40 cycles, and no C resumes afterwards.
- Three `goodColl_i` pulses during one good jingle: exactly one extra jingle follows, and `dropped_o` pulses exactly once.
- `enable` dropped mid-note at edge 20, with `pend_dir` set: `playSound_o` = 0 and `busy_o` = 0 from edge 21. Nothing plays after `enable` returns.
- `nRst` asserted mid-NOTE2: all outputs are 0 immediately. After release, a held-high input generates no event until it falls and rises again.

Source files
------------

// File: rtl/sound_event_sequencer_pkg.sv
// Shared sound-path definitions: mode type, oscillator note codes,
// sequencer state encoding and sound-class encoding.
package sound_event_sequencer_pkg;

   localparam int unsigned FREQ_W = 8;

   typedef enum logic {
      MODE_OFF = 1'b0,
      MODE_ON  = 1'b1
   } MODE_TYPES;

   localparam logic [FREQ_W-1:0] NOTE_A  = FREQ_W'(89);
   localparam logic [FREQ_W-1:0] NOTE_DS = FREQ_W'(126);
   localparam logic [FREQ_W-1:0] NOTE_C  = FREQ_W'(149);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NOTE1 = 2'd1,
      GAP   = 2'd2,
      NOTE2 = 2'd3
   } SEQ_STATE;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      BAD  = 2'd1,
      GOOD = 2'd2,
      DIR  = 2'd3
   } SND_KIND;

endpackage

// File: rtl/sound_event_sequencer_rise_latch.sv
// Rising-edge detector with a one-deep pending flag for one event class.
// Ports:
//   clk, nRst   clock and asynchronous active-low reset
//   enable      low: flag cleared, edges ignored (history still tracks)
//   level       event level, synchronous to clk
//   clr         sequencer is starting this class's sound this cycle
//   pend        registered pending flag
//   drop_c      combinational: an edge arrived while the flag was held
module rise_latch (
   input  logic clk,
   input  logic nRst,
   input  logic enable,
   input  logic level,
   input  logic clr,
   output logic pend,
   output logic drop_c
);

   logic prev;
   logic primed;
   logic rise;

   // The first sample after reset only loads history, so a level that was
   // already high during reset does not count as a new event.
   assign rise   = level & ~prev & primed & enable;
   assign drop_c = rise & pend & ~clr;

   // History and pending flag; a new edge wins over a same-cycle clear.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         prev   <= 1'b0;
         primed <= 1'b0;
         pend   <= 1'b0;
      end else begin
         prev   <= level;
         primed <= 1'b1;
         if (!enable)
            pend <= 1'b0;
         else if (rise)
            pend <= 1'b1;
         else if (clr)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns game-event levels into timed tone requests for the oscillator.
// Ports:
//   clk, nRst     clock (hz100) and asynchronous active-low reset
//   enable        sound mode on
//   goodColl_i    good-collision level
//   badColl_i     bad-collision level
//   direction_i   direction button levels
//   freq_o        oscillator period code (held through gaps and idle)
//   playSound_o   tone active
//   busy_o        sequencer not idle
//   dropped_o     one-cycle pulse when an event is lost
module sound_event_sequencer
   import sound_event_sequencer_pkg::*;
#(
   parameter int unsigned TONE_TICKS = 20,
   parameter int unsigned GAP_TICKS  = 2
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              enable,
   input  logic              goodColl_i,
   input  logic              badColl_i,
   input  logic [3:0]        direction_i,
   output logic [FREQ_W-1:0] freq_o,
   output logic              playSound_o,
   output logic              busy_o,
   output logic              dropped_o
);

   localparam int unsigned TIMER_W = $clog2(2 * TONE_TICKS);
   localparam logic [TIMER_W-1:0] TONE_LOAD = TIMER_W'(TONE_TICKS - 1);
   localparam logic [TIMER_W-1:0] BAD_LOAD  = TIMER_W'(2 * TONE_TICKS - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_TICKS - 1);

   SEQ_STATE            state_q, state_d;
   SND_KIND             kind_q, kind_d, sel_kind, start_kind;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [FREQ_W-1:0]   freq_d;
   logic                gap_final_q, gap_final_d;
   logic                do_start;
   logic                pend_bad, pend_good, pend_dir;
   logic                clr_bad, clr_good, clr_dir;
   logic                drop_bad_c, drop_good_c, drop_dir_c;

   rise_latch u_bad (
      .clk(clk), .nRst(nRst), .enable(enable), .level(badColl_i),
      .clr(clr_bad), .pend(pend_bad), .drop_c(drop_bad_c)
   );

   rise_latch u_good (
      .clk(clk), .nRst(nRst), .enable(enable), .level(goodColl_i),
      .clr(clr_good), .pend(pend_good), .drop_c(drop_good_c)
   );

   rise_latch u_dir (
      .clk(clk), .nRst(nRst), .enable(enable), .level(|direction_i),
      .clr(clr_dir), .pend(pend_dir), .drop_c(drop_dir_c)
   );

   // Highest-priority pending class.
   always_comb begin
      sel_kind = NONE;
      if (pend_bad)
         sel_kind = BAD;
      else if (pend_good)
         sel_kind = GOOD;
      else if (pend_dir)
         sel_kind = DIR;
   end

   // Next-state, timer and note selection.
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      gap_final_d = gap_final_q;
      timer_d     = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
      freq_d      = freq_o;
      do_start    = 1'b0;
      start_kind  = NONE;
      clr_bad     = 1'b0;
      clr_good    = 1'b0;
      clr_dir     = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         kind_d  = NONE;
      end else if (state_q != IDLE && pend_bad && kind_q != BAD) begin
         // Bad collision aborts a good/dir sound; the aborted one is lost.
         do_start   = 1'b1;
         start_kind = BAD;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_kind != NONE) begin
                  do_start   = 1'b1;
                  start_kind = sel_kind;
               end
            end
            NOTE1: begin
               if (timer_q == '0) begin
                  state_d     = GAP;
                  timer_d     = GAP_LOAD;
                  gap_final_d = (kind_q != GOOD);
               end
            end
            GAP: begin
               if (timer_q == '0) begin
                  if (!gap_final_q) begin
                     state_d = NOTE2;
                     timer_d = TONE_LOAD;
                     freq_d  = NOTE_A;
                  end else if (sel_kind != NONE) begin
                     do_start   = 1'b1;
                     start_kind = sel_kind;
                  end else begin
                     state_d = IDLE;
                     kind_d  = NONE;
                  end
               end
            end
            NOTE2: begin
               if (timer_q == '0) begin
                  state_d     = GAP;
                  timer_d     = GAP_LOAD;
                  gap_final_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Starting a sound loads its first note and consumes its flag.
      if (do_start) begin
         state_d = NOTE1;
         kind_d  = start_kind;
         timer_d = (start_kind == BAD) ? BAD_LOAD : TONE_LOAD;
         freq_d  = (start_kind == BAD) ? NOTE_DS : NOTE_C;
         case (start_kind)
            BAD:     clr_bad  = 1'b1;
            GOOD:    clr_good = 1'b1;
            DIR:     clr_dir  = 1'b1;
            default: ;
         endcase
      end
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= IDLE;
         kind_q      <= NONE;
         gap_final_q <= 1'b0;
         timer_q     <= '0;
         freq_o      <= '0;
         playSound_o <= 1'b0;
         busy_o      <= 1'b0;
         dropped_o   <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         gap_final_q <= gap_final_d;
         timer_q     <= timer_d;
         freq_o      <= freq_d;
         playSound_o <= (state_d == NOTE1) || (state_d == NOTE2);
         busy_o      <= (state_d != IDLE);
         dropped_o   <= drop_bad_c | drop_good_c | drop_dir_c;
      end
   end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer with default tick parameters.
module tb_sound_event_sequencer;

   logic       clk = 1'b0;
   logic       nRst;
   logic       enable;
   logic       goodColl_i;
   logic       badColl_i;
   logic [3:0] direction_i;
   logic [7:0] freq_o;
   logic       playSound_o;
   logic       busy_o;
   logic       dropped_o;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   sound_event_sequencer dut (
      .clk(clk), .nRst(nRst), .enable(enable),
      .goodColl_i(goodColl_i), .badColl_i(badColl_i), .direction_i(direction_i),
      .freq_o(freq_o), .playSound_o(playSound_o), .busy_o(busy_o),
      .dropped_o(dropped_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic do_reset();
      nRst        = 1'b0;
      enable      = 1'b1;
      goodColl_i  = 1'b0;
      badColl_i   = 1'b0;
      direction_i = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      nRst   = 1'b1;
      edge_n = 0;
   endtask

   task automatic test_reset();
      nRst = 1'b0; enable = 1'b1; goodColl_i = 0; badColl_i = 0; direction_i = 0;
      #2;
      checks += 4;
      if (freq_o !== 8'd0)    begin failures++; $display("FAIL reset freq got=%0d exp=0", freq_o); end
      if (playSound_o !== 0)  begin failures++; $display("FAIL reset play got=%b exp=0", playSound_o); end
      if (busy_o !== 0)       begin failures++; $display("FAIL reset busy got=%b exp=0", busy_o); end
      if (dropped_o !== 0)    begin failures++; $display("FAIL reset dropped got=%b exp=0", dropped_o); end
      do_reset();
      for (int e = 1; e <= 5; e++) begin
         step();
         checks += 2;
         if (busy_o !== 0)      begin failures++; $display("FAIL reset_idle busy edge=%0d got=%b exp=0", e, busy_o); end
         if (playSound_o !== 0) begin failures++; $display("FAIL reset_idle play edge=%0d got=%b exp=0", e, playSound_o); end
      end
   endtask

   task automatic test_good_jingle();
      logic exp_play, exp_busy;
      logic [7:0] exp_freq;
      do_reset();
      for (int e = 1; e <= 58; e++) begin
         goodColl_i = (e == 10);
         step();
         exp_play = (e >= 11 && e <= 30) || (e >= 33 && e <= 52);
         exp_busy = (e >= 11 && e <= 54);
         exp_freq = (e < 11) ? 8'd0 : (e <= 32) ? 8'd149 : 8'd89;
         checks += 3;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL good play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_busy)      begin failures++; $display("FAIL good busy edge=%0d got=%b exp=%b", e, busy_o, exp_busy); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL good freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
   endtask

   task automatic test_bad_and_dir();
      logic exp_play, exp_busy;
      logic [7:0] exp_freq;
      do_reset();
      for (int e = 1; e <= 78; e++) begin
         badColl_i   = (e == 10);
         direction_i = (e == 10) ? 4'b0001 : 4'b0000;
         step();
         exp_play = (e >= 11 && e <= 50) || (e >= 53 && e <= 72);
         exp_busy = (e >= 11 && e <= 74);
         exp_freq = (e < 11) ? 8'd0 : (e <= 52) ? 8'd126 : 8'd149;
         checks += 3;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL bad_dir play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_busy)      begin failures++; $display("FAIL bad_dir busy edge=%0d got=%b exp=%b", e, busy_o, exp_busy); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL bad_dir freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
   endtask

   task automatic test_preempt();
      logic exp_play, exp_busy;
      logic [7:0] exp_freq;
      do_reset();
      for (int e = 1; e <= 65; e++) begin
         direction_i = (e == 10) ? 4'b0100 : 4'b0000;
         badColl_i   = (e == 15);
         step();
         exp_play = (e >= 11 && e <= 55);
         exp_busy = (e >= 11 && e <= 57);
         exp_freq = (e < 11) ? 8'd0 : (e <= 15) ? 8'd149 : 8'd126;
         checks += 3;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL preempt play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_busy)      begin failures++; $display("FAIL preempt busy edge=%0d got=%b exp=%b", e, busy_o, exp_busy); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL preempt freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_play, exp_busy, exp_drop;
      logic [7:0] exp_freq;
      int drops;
      drops = 0;
      do_reset();
      for (int e = 1; e <= 102; e++) begin
         goodColl_i = (e == 10) || (e == 15) || (e == 20);
         step();
         if (dropped_o === 1'b1) drops++;
         exp_play = (e >= 11 && e <= 30) || (e >= 33 && e <= 52) ||
                    (e >= 55 && e <= 74) || (e >= 77 && e <= 96);
         exp_busy = (e >= 11 && e <= 98);
         exp_drop = (e == 20);
         exp_freq = (e < 11) ? 8'd0 : (e <= 32) ? 8'd149 : (e <= 54) ? 8'd89 :
                    (e <= 76) ? 8'd149 : 8'd89;
         checks += 4;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL b2b play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_busy)      begin failures++; $display("FAIL b2b busy edge=%0d got=%b exp=%b", e, busy_o, exp_busy); end
         if (dropped_o !== exp_drop)   begin failures++; $display("FAIL b2b dropped edge=%0d got=%b exp=%b", e, dropped_o, exp_drop); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL b2b freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
      checks++;
      if (drops !== 1) begin failures++; $display("FAIL b2b drop_count got=%0d exp=1", drops); end
   endtask

   task automatic test_enable();
      logic exp_play, exp_busy;
      logic [7:0] exp_freq;
      do_reset();
      for (int e = 1; e <= 60; e++) begin
         direction_i = (e == 10 || e == 14) ? 4'b0001 : 4'b0000;
         enable      = !(e >= 21 && e <= 25);
         step();
         exp_play = (e >= 11 && e <= 20);
         exp_busy = (e >= 11 && e <= 20);
         exp_freq = (e < 11) ? 8'd0 : 8'd149;
         checks += 3;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL enable play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_busy)      begin failures++; $display("FAIL enable busy edge=%0d got=%b exp=%b", e, busy_o, exp_busy); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL enable freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic exp_play;
      logic [7:0] exp_freq;
      do_reset();
      for (int e = 1; e <= 40; e++) begin
         goodColl_i = (e == 10);
         step();
      end
      checks += 2;
      if (playSound_o !== 1'b1) begin failures++; $display("FAIL rst_mid note2_play got=%b exp=1", playSound_o); end
      if (freq_o !== 8'd89)     begin failures++; $display("FAIL rst_mid note2_freq got=%0d exp=89", freq_o); end
      goodColl_i = 1'b1;
      #2;
      nRst = 1'b0;
      #1;
      checks += 4;
      if (playSound_o !== 0) begin failures++; $display("FAIL rst_mid play got=%b exp=0", playSound_o); end
      if (freq_o !== 8'd0)   begin failures++; $display("FAIL rst_mid freq got=%0d exp=0", freq_o); end
      if (busy_o !== 0)      begin failures++; $display("FAIL rst_mid busy got=%b exp=0", busy_o); end
      if (dropped_o !== 0)   begin failures++; $display("FAIL rst_mid dropped got=%b exp=0", dropped_o); end
      repeat (2) @(posedge clk);
      #1;
      nRst   = 1'b1;
      edge_n = 0;
      for (int e = 1; e <= 40; e++) begin
         goodColl_i = !(e >= 30 && e <= 33);
         step();
         exp_play = (e >= 35);
         exp_freq = (e >= 35) ? 8'd149 : 8'd0;
         checks += 3;
         if (playSound_o !== exp_play) begin failures++; $display("FAIL rst_held play edge=%0d got=%b exp=%b", e, playSound_o, exp_play); end
         if (busy_o !== exp_play)      begin failures++; $display("FAIL rst_held busy edge=%0d got=%b exp=%b", e, busy_o, exp_play); end
         if (freq_o !== exp_freq)      begin failures++; $display("FAIL rst_held freq edge=%0d got=%0d exp=%0d", e, freq_o, exp_freq); end
      end
      goodColl_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_jingle();
      test_bad_and_dir();
      test_preempt();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
